// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB wakeup and single registered dispatch
//
// Holds decoded ALU-class instructions until both source operands are ready,
// snoops the ALU and LSB result broadcasts for wakeup, and sends the
// lowest-index ready entry to the ALU through registered outputs.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global hold), clear (mispredict flush)
//   issue_*        : instruction from the issue stage (op, pc, imm, rob, qj/vj, qk/vk)
//   alu_cdb_*      : ALU result broadcast (valid, name, value)
//   lsb_cdb_*      : LSB result broadcast (valid, name, value)
//   rs_full        : registered, no free entry
//   alu_op/pc/rs1/rs2/imm/name : registered dispatch to the ALU; alu_op=0 means idle
//
// Optional feature macro: RS_CDB_BYPASS_EN
//   When defined, an operand issued as busy whose tag matches a same-cycle
//   broadcast is captured as ready with the broadcast value.

module alu_reservation_station #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        issue_valid,
  input  logic [6:0]  issue_op,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_imm,
  input  logic [4:0]  issue_rob,
  input  logic        issue_qj_busy,
  input  logic [4:0]  issue_qj,
  input  logic [31:0] issue_vj,
  input  logic        issue_qk_busy,
  input  logic [4:0]  issue_qk,
  input  logic [31:0] issue_vk,
  input  logic        alu_cdb_valid,
  input  logic [4:0]  alu_cdb_name,
  input  logic [31:0] alu_cdb_value,
  input  logic        lsb_cdb_valid,
  input  logic [4:0]  lsb_cdb_name,
  input  logic [31:0] lsb_cdb_value,
  output logic        rs_full,
  output logic [6:0]  alu_op,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_imm,
  output logic [4:0]  alu_name
);

  localparam logic [RS_IDX_W:0] FULL_COUNT = (RS_IDX_W+1)'(RS_SIZE);

  logic        busy_q    [RS_SIZE];
  logic        busy_d    [RS_SIZE];
  logic [6:0]  op_q      [RS_SIZE];
  logic [6:0]  op_d      [RS_SIZE];
  logic [31:0] pc_q      [RS_SIZE];
  logic [31:0] pc_d      [RS_SIZE];
  logic [31:0] imm_q     [RS_SIZE];
  logic [31:0] imm_d     [RS_SIZE];
  logic [4:0]  rob_q     [RS_SIZE];
  logic [4:0]  rob_d     [RS_SIZE];
  logic        qj_busy_q [RS_SIZE];
  logic        qj_busy_d [RS_SIZE];
  logic [4:0]  qj_q      [RS_SIZE];
  logic [4:0]  qj_d      [RS_SIZE];
  logic [31:0] vj_q      [RS_SIZE];
  logic [31:0] vj_d      [RS_SIZE];
  logic        qk_busy_q [RS_SIZE];
  logic        qk_busy_d [RS_SIZE];
  logic [4:0]  qk_q      [RS_SIZE];
  logic [4:0]  qk_d      [RS_SIZE];
  logic [31:0] vk_q      [RS_SIZE];
  logic [31:0] vk_d      [RS_SIZE];

  logic [RS_IDX_W:0] count_q, count_d;
  logic              rs_full_q, rs_full_d;
  logic [6:0]        alu_op_q, alu_op_d;
  logic [31:0]       alu_pc_q, alu_pc_d;
  logic [31:0]       alu_rs1_q, alu_rs1_d;
  logic [31:0]       alu_rs2_q, alu_rs2_d;
  logic [31:0]       alu_imm_q, alu_imm_d;
  logic [4:0]        alu_name_q, alu_name_d;

  logic                ready_found, free_found, issue_take;
  logic [RS_IDX_W-1:0] ready_idx, free_idx;

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rob_d     = rob_q;
    qj_busy_d = qj_busy_q;
    qj_d      = qj_q;
    vj_d      = vj_q;
    qk_busy_d = qk_busy_q;
    qk_d      = qk_q;
    vk_d      = vk_q;
    count_d    = count_q;
    rs_full_d  = rs_full_q;
    alu_op_d   = alu_op_q;
    alu_pc_d   = alu_pc_q;
    alu_rs1_d  = alu_rs1_q;
    alu_rs2_d  = alu_rs2_q;
    alu_imm_d  = alu_imm_q;
    alu_name_d = alu_name_q;
    ready_found = 1'b0;
    ready_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    issue_take  = 1'b0;

    // Scanning downward leaves the lowest matching index in the result.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i]) begin
        ready_found = 1'b1;
        ready_idx   = RS_IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end

    if (rdy) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++) busy_d[i] = 1'b0;
        count_d   = '0;
        rs_full_d = 1'b0;
        alu_op_d  = '0;
      end else begin
        alu_op_d = '0;
        if (ready_found) begin
          alu_op_d   = op_q[ready_idx];
          alu_pc_d   = pc_q[ready_idx];
          alu_rs1_d  = vj_q[ready_idx];
          alu_rs2_d  = vk_q[ready_idx];
          alu_imm_d  = imm_q[ready_idx];
          alu_name_d = rob_q[ready_idx];
          busy_d[ready_idx] = 1'b0;
        end

        // ALU broadcast is checked first so it wins if both match.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qj_busy_q[i]) begin
            if (alu_cdb_valid && alu_cdb_name == qj_q[i]) begin
              qj_busy_d[i] = 1'b0;
              vj_d[i]      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_name == qj_q[i]) begin
              qj_busy_d[i] = 1'b0;
              vj_d[i]      = lsb_cdb_value;
            end
          end
          if (busy_q[i] && qk_busy_q[i]) begin
            if (alu_cdb_valid && alu_cdb_name == qk_q[i]) begin
              qk_busy_d[i] = 1'b0;
              vk_d[i]      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_name == qk_q[i]) begin
              qk_busy_d[i] = 1'b0;
              vk_d[i]      = lsb_cdb_value;
            end
          end
        end

        // Free slot comes from registered state, so a slot being vacated by
        // this cycle's dispatch is not reused until the next cycle.
        issue_take = issue_valid && !rs_full_q && free_found;
        if (issue_take) begin
          busy_d[free_idx]    = 1'b1;
          op_d[free_idx]      = issue_op;
          pc_d[free_idx]      = issue_pc;
          imm_d[free_idx]     = issue_imm;
          rob_d[free_idx]     = issue_rob;
          qj_busy_d[free_idx] = issue_qj_busy;
          qj_d[free_idx]      = issue_qj;
          vj_d[free_idx]      = issue_vj;
          qk_busy_d[free_idx] = issue_qk_busy;
          qk_d[free_idx]      = issue_qk;
          vk_d[free_idx]      = issue_vk;
`ifdef RS_CDB_BYPASS_EN
          if (issue_qj_busy && alu_cdb_valid && alu_cdb_name == issue_qj) begin
            qj_busy_d[free_idx] = 1'b0;
            vj_d[free_idx]      = alu_cdb_value;
          end else if (issue_qj_busy && lsb_cdb_valid && lsb_cdb_name == issue_qj) begin
            qj_busy_d[free_idx] = 1'b0;
            vj_d[free_idx]      = lsb_cdb_value;
          end
          if (issue_qk_busy && alu_cdb_valid && alu_cdb_name == issue_qk) begin
            qk_busy_d[free_idx] = 1'b0;
            vk_d[free_idx]      = alu_cdb_value;
          end else if (issue_qk_busy && lsb_cdb_valid && lsb_cdb_name == issue_qk) begin
            qk_busy_d[free_idx] = 1'b0;
            vk_d[free_idx]      = lsb_cdb_value;
          end
`endif
        end

        if (issue_take && !ready_found) count_d = count_q + 1'b1;
        else if (!issue_take && ready_found) count_d = count_q - 1'b1;
        rs_full_d = (count_d == FULL_COUNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i]    <= 1'b0;
        op_q[i]      <= '0;
        pc_q[i]      <= '0;
        imm_q[i]     <= '0;
        rob_q[i]     <= '0;
        qj_busy_q[i] <= 1'b0;
        qj_q[i]      <= '0;
        vj_q[i]      <= '0;
        qk_busy_q[i] <= 1'b0;
        qk_q[i]      <= '0;
        vk_q[i]      <= '0;
      end
      count_q    <= '0;
      rs_full_q  <= 1'b0;
      alu_op_q   <= '0;
      alu_pc_q   <= '0;
      alu_rs1_q  <= '0;
      alu_rs2_q  <= '0;
      alu_imm_q  <= '0;
      alu_name_q <= '0;
    end else begin
      busy_q     <= busy_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rob_q      <= rob_d;
      qj_busy_q  <= qj_busy_d;
      qj_q       <= qj_d;
      vj_q       <= vj_d;
      qk_busy_q  <= qk_busy_d;
      qk_q       <= qk_d;
      vk_q       <= vk_d;
      count_q    <= count_d;
      rs_full_q  <= rs_full_d;
      alu_op_q   <= alu_op_d;
      alu_pc_q   <= alu_pc_d;
      alu_rs1_q  <= alu_rs1_d;
      alu_rs2_q  <= alu_rs2_d;
      alu_imm_q  <= alu_imm_d;
      alu_name_q <= alu_name_d;
    end
  end

  assign rs_full  = rs_full_q;
  assign alu_op   = alu_op_q;
  assign alu_pc   = alu_pc_q;
  assign alu_rs1  = alu_rs1_q;
  assign alu_rs2  = alu_rs2_q;
  assign alu_imm  = alu_imm_q;
  assign alu_name = alu_name_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - self-checking bench for alu_reservation_station

module tb_alu_reservation_station;

  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_valid;
  logic [6:0]  issue_op;
  logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
  logic [4:0]  issue_rob, issue_qj, issue_qk;
  logic        issue_qj_busy, issue_qk_busy;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [4:0]  alu_cdb_name, lsb_cdb_name;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        rs_full;
  logic [6:0]  alu_op;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [4:0]  alu_name;

  always #5 clk = ~clk;

  alu_reservation_station #(.RS_SIZE(RS), .RS_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_rob(issue_rob),
    .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_vj(issue_vj),
    .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_name(alu_cdb_name), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_name(lsb_cdb_name), .lsb_cdb_value(lsb_cdb_value),
    .rs_full(rs_full), .alu_op(alu_op), .alu_pc(alu_pc), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_name(alu_name)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mcheck = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        w;
    logic [31:0] v;
  } opnd_t;

  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rob;
    logic [4:0]  qj;
    logic [4:0]  qk;
    opnd_t       j;
    opnd_t       k;
  } ent_t;

  ent_t        m_ent [RS];
  bit          m_full;
  logic [6:0]  m_op;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_name;

  function automatic opnd_t snoop(input opnd_t o, input logic [4:0] tag);
    opnd_t r;
    r = o;
    if (o.w) begin
      if (alu_cdb_valid && alu_cdb_name == tag) r = '{w: 1'b0, v: alu_cdb_value};
      else if (lsb_cdb_valid && lsb_cdb_name == tag) r = '{w: 1'b0, v: lsb_cdb_value};
    end
    return r;
  endfunction

  task automatic model_step();
    ent_t nx [RS];
    int   ri, fi, cnt;
    if (rst) begin
      for (int i = 0; i < RS; i++) m_ent[i] = '{busy: 0, op: 0, pc: 0, imm: 0, rob: 0, qj: 0, qk: 0, j: '0, k: '0};
      m_full = 0; m_op = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_name = 0;
      return;
    end
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < RS; i++) m_ent[i].busy = 0;
      m_full = 0;
      m_op = 0;
      return;
    end
    nx = m_ent;
    ri = -1;
    for (int i = 0; i < RS; i++)
      if (ri < 0 && m_ent[i].busy && !m_ent[i].j.w && !m_ent[i].k.w) ri = i;
    if (ri >= 0) begin
      m_op = m_ent[ri].op; m_pc = m_ent[ri].pc; m_rs1 = m_ent[ri].j.v;
      m_rs2 = m_ent[ri].k.v; m_imm = m_ent[ri].imm; m_name = m_ent[ri].rob;
      nx[ri].busy = 0;
    end else begin
      m_op = 0;
    end
    for (int i = 0; i < RS; i++) begin
      if (m_ent[i].busy) begin
        nx[i].j = snoop(m_ent[i].j, m_ent[i].qj);
        nx[i].k = snoop(m_ent[i].k, m_ent[i].qk);
      end
    end
    if (issue_valid && !m_full) begin
      fi = -1;
      for (int i = 0; i < RS; i++) if (fi < 0 && !m_ent[i].busy) fi = i;
      if (fi >= 0) begin
        nx[fi].busy = 1; nx[fi].op = issue_op; nx[fi].pc = issue_pc;
        nx[fi].imm = issue_imm; nx[fi].rob = issue_rob;
        nx[fi].qj = issue_qj; nx[fi].qk = issue_qk;
        nx[fi].j = '{w: issue_qj_busy, v: issue_vj};
        nx[fi].k = '{w: issue_qk_busy, v: issue_vk};
`ifdef RS_CDB_BYPASS_EN
        nx[fi].j = snoop(nx[fi].j, issue_qj);
        nx[fi].k = snoop(nx[fi].k, issue_qk);
`endif
      end
    end
    m_ent = nx;
    cnt = 0;
    for (int i = 0; i < RS; i++) if (m_ent[i].busy) cnt++;
    m_full = (cnt == RS);
  endtask

  task automatic model_compare();
    chk("rnd.rs_full", 32'(rs_full), 32'(m_full));
    chk("rnd.alu_op", 32'(alu_op), 32'(m_op));
    if (m_op != 0) begin
      chk("rnd.alu_pc", alu_pc, m_pc);
      chk("rnd.alu_rs1", alu_rs1, m_rs1);
      chk("rnd.alu_rs2", alu_rs2, m_rs2);
      chk("rnd.alu_imm", alu_imm, m_imm);
      chk("rnd.alu_name", 32'(alu_name), 32'(m_name));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (mcheck) model_compare();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clear = 0;
    issue_valid = 0; issue_op = 0; issue_pc = 0; issue_imm = 0; issue_rob = 0;
    issue_qj_busy = 0; issue_qj = 0; issue_vj = 0;
    issue_qk_busy = 0; issue_qk = 0; issue_vk = 0;
    alu_cdb_valid = 0; alu_cdb_name = 0; alu_cdb_value = 0;
    lsb_cdb_valid = 0; lsb_cdb_name = 0; lsb_cdb_value = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic iss(input logic [6:0] op, input logic [4:0] rob, input logic [31:0] vj,
                     input logic [31:0] vk, input logic [31:0] imm, input logic jb, input logic [4:0] qj);
    issue_valid = 1; issue_op = op; issue_rob = rob; issue_pc = 32'h1000 + 32'(rob);
    issue_vj = vj; issue_vk = vk; issue_imm = imm; issue_qj_busy = jb; issue_qj = qj;
    issue_qk_busy = 0; issue_qk = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       nm;
    logic        iv;
    logic [6:0]  op;
    logic [31:0] vj;
    logic [31:0] imm;
    logic [4:0]  rob;
    logic        jb;
    logic [4:0]  qj;
    logic        av;
    logic [4:0]  an;
    logic [31:0] aval;
    logic        clr;
    logic        e_full;
    logic [6:0]  e_op;
    logic [31:0] e_rs1;
    logic [31:0] e_imm;
    logic [4:0]  e_name;
  } vec_t;

  localparam logic [6:0] OP_ADDI = 7'd10;
  localparam logic [6:0] OP_ADD  = 7'd20;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"addi_issue", 1, OP_ADDI, 5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"addi_disp",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADDI, 5, 3, 7});
    vecs.push_back('{"addi_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"add_issue",  1, OP_ADD, 0, 0, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"add_wake",   0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h10, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"add_disp",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_ADD, 32'h10, 0, 3});
    vecs.push_back('{"add_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_fill0",  1, 7'd30, 0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_fill1",  1, 7'd31, 0, 0, 2, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_fill2",  1, 7'd32, 0, 0, 3, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_issue",  1, 7'd40, 9, 0, 20, 0, 0, 1, 12, 1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_wake",   0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_idle1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"clr_idle2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
  end

  initial begin
    #1;
    do_reset();
    chk("reset.rs_full", 32'(rs_full), 0);
    chk("reset.alu_op", 32'(alu_op), 0);
    chk("reset.alu_rs1", alu_rs1, 0);
    chk("reset.alu_name", 32'(alu_name), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      idle();
      if (vecs[i].iv) iss(vecs[i].op, vecs[i].rob, vecs[i].vj, 0, vecs[i].imm, vecs[i].jb, vecs[i].qj);
      alu_cdb_valid = vecs[i].av; alu_cdb_name = vecs[i].an; alu_cdb_value = vecs[i].aval;
      clear = vecs[i].clr;
      step();
      chk({vecs[i].nm, ".rs_full"}, 32'(rs_full), 32'(vecs[i].e_full));
      chk({vecs[i].nm, ".alu_op"}, 32'(alu_op), 32'(vecs[i].e_op));
      if (vecs[i].e_op != 0) begin
        chk({vecs[i].nm, ".alu_rs1"}, alu_rs1, vecs[i].e_rs1);
        chk({vecs[i].nm, ".alu_imm"}, alu_imm, vecs[i].e_imm);
        chk({vecs[i].nm, ".alu_name"}, 32'(alu_name), 32'(vecs[i].e_name));
      end
    end

    // fill all entries waiting on tag 9, then drain in index order
    for (int k = 0; k < RS; k++) begin
      idle();
      iss(7'(k + 1), 5'(k), 0, 32'h5000 + 32'(k), 32'(k), 1, 9);
      step();
      chk("fill.rs_full", 32'(rs_full), (k == RS - 1) ? 32'd1 : 32'd0);
    end
    idle();
    iss(7'd99, 5'd20, 0, 0, 0, 0, 0);
    step();
    chk("drop.rs_full", 32'(rs_full), 1);
    idle();
    lsb_cdb_valid = 1; lsb_cdb_name = 9; lsb_cdb_value = 32'hC0DE;
    step();
    chk("wake9.alu_op", 32'(alu_op), 0);
    chk("wake9.rs_full", 32'(rs_full), 1);
    for (int k = 0; k < RS; k++) begin
      idle();
      step();
      chk("drain.alu_op", 32'(alu_op), 32'(k + 1));
      chk("drain.alu_name", 32'(alu_name), 32'(k));
      chk("drain.alu_rs1", alu_rs1, 32'hC0DE);
      chk("drain.alu_rs2", alu_rs2, 32'h5000 + 32'(k));
      chk("drain.rs_full", 32'(rs_full), 0);
    end
    idle();
    step();
    chk("drain_end.alu_op", 32'(alu_op), 0);

    // issue and dispatch together at count RS-1
    for (int k = 0; k < RS - 1; k++) begin
      idle();
      iss(7'(k + 1), 5'(k), 0, 0, 0, 1, (k == 0) ? 5'd8 : 5'd9);
      step();
    end
    chk("c15.rs_full", 32'(rs_full), 0);
    idle();
    alu_cdb_valid = 1; alu_cdb_name = 8; alu_cdb_value = 32'h88;
    step();
    chk("c15_wake.alu_op", 32'(alu_op), 0);
    idle();
    iss(7'd77, 5'd30, 32'hAAA, 32'h0, 32'h0, 0, 0);
    step();
    chk("c15_both.alu_op", 32'(alu_op), 1);
    chk("c15_both.alu_rs1", alu_rs1, 32'h88);
    chk("c15_both.alu_name", 32'(alu_name), 0);
    chk("c15_both.rs_full", 32'(rs_full), 0);
    idle();
    iss(7'd78, 5'd31, 0, 0, 0, 1, 9);
    step();
    chk("c15_new.alu_op", 32'(alu_op), 77);
    chk("c15_new.alu_rs1", alu_rs1, 32'hAAA);
    chk("c15_new.alu_name", 32'(alu_name), 30);
    chk("c15_new.rs_full", 32'(rs_full), 0);
    idle();
    iss(7'd79, 5'd29, 0, 0, 0, 1, 9);
    step();
    chk("c16.alu_op", 32'(alu_op), 0);
    chk("c16.rs_full", 32'(rs_full), 1);

    // same-cycle broadcast at issue
    do_reset();
    idle();
    iss(7'd60, 5'd11, 0, 0, 0, 1, 2);
    alu_cdb_valid = 1; alu_cdb_name = 2; alu_cdb_value = 32'hAB;
    step();
    chk("byp_issue.alu_op", 32'(alu_op), 0);
    idle();
    step();
`ifdef RS_CDB_BYPASS_EN
    chk("byp.alu_op", 32'(alu_op), 60);
    chk("byp.alu_rs1", alu_rs1, 32'hAB);
`else
    chk("nobyp.alu_op", 32'(alu_op), 0);
`endif
    idle();
    step();
    chk("byp_after.alu_op", 32'(alu_op), 0);

    // randomized run against the model
    do_reset();
    mcheck = 1;
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom % 10) != 0;
      clear = ($urandom % 40) == 0;
      issue_valid = ($urandom % 3) != 0;
      issue_op = 7'($urandom_range(1, 127));
      issue_pc = $urandom; issue_imm = $urandom;
      issue_rob = 5'($urandom);
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj_busy = 1'($urandom % 2); issue_qj = 5'($urandom_range(0, 7));
      issue_qk_busy = 1'($urandom % 2); issue_qk = 5'($urandom_range(0, 7));
      alu_cdb_valid = 1'($urandom % 2); alu_cdb_name = 5'($urandom_range(0, 7));
      alu_cdb_value = $urandom;
      lsb_cdb_valid = 1'($urandom % 2); lsb_cdb_name = 5'($urandom_range(0, 7));
      lsb_cdb_value = $urandom;
      step();
    end
    mcheck = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the ALU in the Tomasulo back end.
- Accepts decoded ALU-class instructions (LUI, AUIPC, JAL, JALR, branches, immediate ops, register ops) from the issue stage and holds them until both source operands are ready.
- Snoops the ALU and LSB result broadcasts for operand wakeup.
- Dispatches at most one ready entry per cycle to the ALU through registered outputs.

Parameters:
- RS_SIZE, 16, number of entries; power of two, 2..32.
- RS_IDX_W, 4, log2(RS_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state and outputs hold
- clear  in  1  mispredict flush
- issue_valid  in  1  new instruction this cycle
- issue_op  in  7  internal op code; 0 is illegal
- issue_pc  in  32  instruction pc
- issue_imm  in  32  immediate
- issue_rob  in  5  destination ROB tag
- issue_qj_busy  in  1  rs1 waits on tag issue_qj
- issue_qj  in  5  rs1 producer tag
- issue_vj  in  32  rs1 value when not busy
- issue_qk_busy  in  1  rs2 waits on tag issue_qk
- issue_qk  in  5  rs2 producer tag
- issue_vk  in  32  rs2 value when not busy
- alu_cdb_valid  in  1  ALU broadcast valid
- alu_cdb_name  in  5  ALU broadcast tag
- alu_cdb_value  in  32  ALU broadcast value
- lsb_cdb_valid  in  1  LSB broadcast valid
- lsb_cdb_name  in  5  LSB broadcast tag
- lsb_cdb_value  in  32  LSB broadcast value
- rs_full  out  1  no free entry
- alu_op  out  7  op to ALU; 0 means no operation
- alu_pc  out  32  pc to ALU
- alu_rs1  out  32  operand 1
- alu_rs2  out  32  operand 2
- alu_imm  out  32  immediate
- alu_name  out  5  ROB tag to ALU

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Entry fields: busy, op, pc, imm, rob, qj_busy, qj, vj, qk_busy, qk, vk.
- Reset: all entries not busy, entry count 0, rs_full=0, alu_op=0, all other outputs 0.
- rdy low: nothing changes. Broadcasts seen while rdy is low are ignored; the producer holds them.
- Priority each rdy cycle: clear > (dispatch, wakeup, issue).
- clear:
  - All entries not busy, count 0, alu_op=0 next cycle.
  - Any issue or broadcast in the same cycle is dropped.
- Issue:
  - If issue_valid and not rs_full, write the lowest-index free entry.
  - If issue_valid while rs_full, the instruction is dropped. The issue stage must not do this.
- Wakeup:
  - For every busy entry, if qj_busy and a valid broadcast tag equals qj, set vj to that value and clear qj_busy. Same for qk.
  - ALU and LSB broadcasts are checked independently. If both match the same operand, the ALU value wins (same tag cannot legally occur twice).
- Ready: busy and !qj_busy and !qk_busy, evaluated on registered state. An entry woken in cycle N is eligible in cycle N+1.
- Dispatch:
  - Select the lowest-index ready entry. Next edge: alu_op/pc/rs1=vj/rs2=vk/imm/name take its fields, and the entry is freed.
  - If no entry is ready, alu_op=0 next edge; other outputs may hold.
  - Latency: issue with both operands ready at edge N, alu_op valid after edge N+1.
- Count: +1 on accepted issue, -1 on dispatch, unchanged when both happen.
- rs_full:
  - Registered; equals (next count == RS_SIZE).
  - A slot freed by dispatch this cycle is visible as not-full the next cycle.
  - An issue and a dispatch in the same cycle are both legal when count==RS_SIZE-1.
- Tag 0 is a valid ROB tag; no special meaning.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined:
  - On issue, an operand marked busy whose tag matches a same-cycle valid ALU or LSB broadcast is captured as ready with the broadcast value.
  - Such an entry is eligible for dispatch the next cycle.
- Undefined:
  - Issue fields are stored as given, and wakeup applies only to entries already resident.
  - The issue stage is required to have resolved same-cycle broadcasts itself.

Test Plan:
1. Reset, then issue ADDI (vj=5, imm=3, rob=7, both ready) -> two edges later alu_op=ADDI, alu_rs1=5, alu_imm=3, alu_name=7; the following cycle alu_op=0.
2. Issue ADD with qj_busy tag 4, then alu_cdb_valid name=4 value=0x10 -> alu_op=ADD on the cycle after wakeup, with alu_rs1=0x10.
3. Fill all 16 entries with operands busy on tag 9 -> rs_full=1. Broadcast tag 9 on LSB -> entries dispatch in index order 0..15, one per cycle, and rs_full drops after the first dispatch.
4. Issue and dispatch in the same cycle at count 15 -> count stays 15, rs_full=0, and both the issued and dispatched instructions are correct.
5. With 3 entries busy, assert clear with issue_valid=1 -> count 0, alu_op=0 next cycle, and the issued instruction never dispatches.
6. RS_CDB_BYPASS_EN defined: issue qj_busy tag 2 while alu_cdb_name=2 value=0xAB -> dispatched next cycle with alu_rs1=0xAB. Undefined: the entry stays waiting.
